// File: rtl/ppu_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ppu_sched_pkg
// Description : Shared types and constants for the PPU row scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package ppu_sched_pkg;

    localparam int         DEF_NUM_ROWS = 240;
    localparam logic [7:0] UNDERRUN_SAT = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SYNC      = 3'd1,
        ST_VBWAIT    = 3'd2,
        ST_RENDER    = 3'd3,
        ST_WAIT_SWAP = 3'd4,
        ST_WAIT_VB   = 3'd5
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/ppu_row_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : ppu_row_scheduler_if
// Description : Scan-out timing, PPU render command and VRAM sync signals
//               seen by the row scheduler. master = scheduler side,
//               slave = HDMI/PPU/VRAM side.
// Revision    : 1.0 - initial release
// ============================================================================
interface ppu_row_scheduler_if #(
    parameter int ROW_W   = 8,
    parameter int FRAME_W = 16
);
    logic               rowram_swap;
    logic               vblank_start;
    logic               vblank_end_soon;
    logic               render_start;
    logic [ROW_W-1:0]   render_row;
    logic               render_done;
    logic               render_abort;
    logic               vram_sync_req;
    logic               vram_sync_ack;
    logic               in_vblank;
    logic [FRAME_W-1:0] frame_count;
    logic               underrun;
    logic [7:0]         underrun_count;
    logic               desync;

    modport master (
        input  rowram_swap, vblank_start, vblank_end_soon, render_done, vram_sync_ack,
        output render_start, render_row, render_abort, vram_sync_req, in_vblank,
               frame_count, underrun, underrun_count, desync
    );

    modport slave (
        output rowram_swap, vblank_start, vblank_end_soon, render_done, vram_sync_ack,
        input  render_start, render_row, render_abort, vram_sync_req, in_vblank,
               frame_count, underrun, underrun_count, desync
    );
endinterface
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : 8-bit incrementer that sticks at UNDERRUN_SAT; cleared only
//               by the synchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter
    import ppu_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_inc,
    output logic [7:0] o_count
);
    logic [7:0] r_count;

    // Count increment requests, holding at the saturation value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 8'd0;
        end else if (i_inc && (r_count != UNDERRUN_SAT)) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign o_count = r_count;
endmodule
`default_nettype wire

// File: rtl/ppu_row_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : ppu_row_scheduler
// Description : Issues one PPU render command per visible row in lockstep
//               with HDMI row-RAM swaps, runs the per-frame VRAM sync during
//               vblank, and flags row underruns and frame desync.
// Revision    : 1.0 - initial release
// ============================================================================
module ppu_row_scheduler
    import ppu_sched_pkg::*;
#(
    parameter int NUM_ROWS = DEF_NUM_ROWS,
    parameter int ROW_W    = 8,
    parameter int FRAME_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    ppu_row_scheduler_if.master bus
);
    localparam logic [ROW_W-1:0] c_LAST_ROW = ROW_W'(NUM_ROWS - 1);

    sched_state_t       r_state;
    logic [ROW_W-1:0]   r_row;
    logic [FRAME_W-1:0] r_frame;
    logic               r_pending;
    logic               r_start;
    logic               r_abort;
    logic               r_underrun;
    logic               r_desync;
    logic               r_req;
    logic               r_in_vblank;
    logic [7:0]         w_underrun_count;
    logic               w_underrun_evt;
    logic               w_advance;

    // A swap landing while the row is still rendering is an underrun;
    // vblank_start takes priority over everything else.
    assign w_underrun_evt = !bus.vblank_start && (r_state == ST_RENDER)
                          && bus.rowram_swap && !bus.render_done;

    // The row RAM has been both filled and taken: move to the next row.
    assign w_advance = !bus.vblank_start &&
                       (((r_state == ST_WAIT_SWAP) && bus.rowram_swap) ||
                        ((r_state == ST_RENDER) && bus.render_done &&
                         (r_pending || bus.rowram_swap)));

    // Scheduler state machine with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_row       <= '0;
            r_frame     <= '0;
            r_pending   <= 1'b0;
            r_start     <= 1'b0;
            r_abort     <= 1'b0;
            r_underrun  <= 1'b0;
            r_desync    <= 1'b0;
            r_req       <= 1'b0;
            r_in_vblank <= 1'b0;
        end else begin
            r_start    <= 1'b0;
            r_abort    <= 1'b0;
            r_underrun <= 1'b0;
            r_desync   <= 1'b0;
            if (bus.vblank_start) begin
                // Only IDLE and WAIT_VB expect vblank; anywhere else the frame slipped.
                r_desync    <= (r_state != ST_IDLE) && (r_state != ST_WAIT_VB);
                r_abort     <= (r_state == ST_RENDER);
                r_pending   <= 1'b0;
                r_state     <= ST_SYNC;
                r_req       <= 1'b1;
                r_in_vblank <= 1'b1;
            end else begin
                case (r_state)
                    ST_SYNC: begin
                        if (bus.vram_sync_ack) begin
                            r_req   <= 1'b0;
                            r_frame <= r_frame + FRAME_W'(1);
                            r_state <= ST_VBWAIT;
                        end
                    end
                    ST_VBWAIT: begin
                        if (bus.vblank_end_soon) begin
                            r_row       <= '0;
                            r_start     <= 1'b1;
                            r_in_vblank <= 1'b0;
                            r_state     <= ST_RENDER;
                        end
                    end
                    ST_RENDER: begin
                        if (bus.render_done) begin
                            r_pending <= 1'b0;
                            if (!r_pending && !bus.rowram_swap) begin
                                r_state <= ST_WAIT_SWAP;
                            end
                        end else if (bus.rowram_swap) begin
                            r_underrun <= 1'b1;
                            r_pending  <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
                if (w_advance) begin
                    if (r_row != c_LAST_ROW) begin
                        r_row   <= r_row + ROW_W'(1);
                        r_start <= 1'b1;
                        r_state <= ST_RENDER;
                    end else begin
                        r_state <= ST_WAIT_VB;
                    end
                end
            end
        end
    end

    sat_counter u_underrun_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_underrun_evt),
        .o_count (w_underrun_count)
    );

    assign bus.render_start   = r_start;
    assign bus.render_row     = r_row;
    assign bus.render_abort   = r_abort;
    assign bus.vram_sync_req  = r_req;
    assign bus.in_vblank      = r_in_vblank;
    assign bus.frame_count    = r_frame;
    assign bus.underrun       = r_underrun;
    assign bus.underrun_count = w_underrun_count;
    assign bus.desync         = r_desync;
endmodule
`default_nettype wire

// File: tb/tb_ppu_row_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_ppu_row_scheduler
// Description : Directed self-checking bench for ppu_row_scheduler with a
//               frame-level reference model and literal spot checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ppu_row_scheduler;
    localparam int c_ROWS = 4;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    ppu_row_scheduler_if #(.ROW_W(8), .FRAME_W(16)) bus ();

    ppu_row_scheduler #(.NUM_ROWS(c_ROWS), .ROW_W(8), .FRAME_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (frame-level view) ----------------
    localparam int P_IDLE = 0, P_SYNC = 1, P_VBWAIT = 2, P_RENDER = 3, P_WAIT_SWAP = 4, P_WAIT_VB = 5;
    int  m_phase = P_IDLE;
    int  m_row = 0, m_frame = 0, m_uc = 0;
    bit  m_owed = 0, m_valid = 0;
    bit  e_start = 0, e_abort = 0, e_under = 0, e_desync = 0, e_req = 0, e_inv = 0;

    always @(posedge clk) begin
        e_start = 0; e_abort = 0; e_under = 0; e_desync = 0;
        if (rst) begin
            m_valid = 1; m_phase = P_IDLE; m_row = 0; m_frame = 0; m_uc = 0; m_owed = 0;
        end else if (bus.vblank_start) begin
            e_desync = !(m_phase == P_IDLE || m_phase == P_WAIT_VB);
            e_abort  = (m_phase == P_RENDER);
            m_owed   = 0;
            m_phase  = P_SYNC;
        end else begin
            bit row_complete;
            row_complete = 0;
            if (m_phase == P_SYNC && bus.vram_sync_ack) begin
                m_frame = (m_frame + 1) % 65536;
                m_phase = P_VBWAIT;
            end else if (m_phase == P_VBWAIT && bus.vblank_end_soon) begin
                m_row = 0; e_start = 1; m_phase = P_RENDER;
            end else if (m_phase == P_RENDER && bus.render_done) begin
                if (m_owed || bus.rowram_swap) row_complete = 1;
                else m_phase = P_WAIT_SWAP;
                m_owed = 0;
            end else if (m_phase == P_RENDER && bus.rowram_swap) begin
                e_under = 1; m_owed = 1;
                if (m_uc < 255) m_uc++;
            end else if (m_phase == P_WAIT_SWAP && bus.rowram_swap) begin
                row_complete = 1;
            end
            if (row_complete) begin
                if (m_row < c_ROWS - 1) begin
                    m_row++; e_start = 1; m_phase = P_RENDER;
                end else begin
                    m_phase = P_WAIT_VB;
                end
            end
        end
        e_req = (m_phase == P_SYNC);
        e_inv = (m_phase == P_SYNC) || (m_phase == P_VBWAIT);
    end

    // Compare every output against the model away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("m_start",  32'(bus.render_start),   32'(e_start));
            chk("m_row",    32'(bus.render_row),     32'(m_row));
            chk("m_abort",  32'(bus.render_abort),   32'(e_abort));
            chk("m_req",    32'(bus.vram_sync_req),  32'(e_req));
            chk("m_inv",    32'(bus.in_vblank),      32'(e_inv));
            chk("m_frame",  32'(bus.frame_count),    32'(m_frame));
            chk("m_under",  32'(bus.underrun),       32'(e_under));
            chk("m_ucount", 32'(bus.underrun_count), 32'(m_uc));
            chk("m_desync", 32'(bus.desync),         32'(e_desync));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle pulse on any combination of inputs; returns #1 after the
    // edge that sampled it, so registered responses are visible.
    task automatic pulse(input bit vs, input bit ve, input bit sw, input bit dn, input bit ak);
        bus.vblank_start    = vs;
        bus.vblank_end_soon = ve;
        bus.rowram_swap     = sw;
        bus.render_done     = dn;
        bus.vram_sync_ack   = ak;
        step(1);
        bus.vblank_start    = 1'b0;
        bus.vblank_end_soon = 1'b0;
        bus.rowram_swap     = 1'b0;
        bus.render_done     = 1'b0;
        bus.vram_sync_ack   = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.vblank_start = 1'b0; bus.vblank_end_soon = 1'b0; bus.rowram_swap = 1'b0;
        bus.render_done  = 1'b0; bus.vram_sync_ack   = 1'b0;
        step(3);
        chk("rst_row",   32'(bus.render_row),     32'd0);
        chk("rst_frame", 32'(bus.frame_count),    32'd0);
        chk("rst_uc",    32'(bus.underrun_count), 32'd0);
        chk("rst_req",   32'(bus.vram_sync_req),  32'd0);
        chk("rst_inv",   32'(bus.in_vblank),      32'd0);
        rst = 1'b0;
        step(2);

        // Normal frame
        pulse(1, 0, 0, 0, 0);
        chk("f1_req",    32'(bus.vram_sync_req), 32'd1);
        chk("f1_desync", 32'(bus.desync),        32'd0);
        step(2);
        pulse(0, 0, 0, 0, 1);
        chk("f1_frame", 32'(bus.frame_count),   32'd1);
        chk("f1_req0",  32'(bus.vram_sync_req), 32'd0);
        chk("f1_inv",   32'(bus.in_vblank),     32'd1);
        step(1);
        pulse(0, 1, 0, 0, 0);
        chk("r0_start", 32'(bus.render_start), 32'd1);
        chk("r0_row",   32'(bus.render_row),   32'd0);
        for (int r = 0; r < c_ROWS; r++) begin
            step(2);
            pulse(0, 0, 0, 1, 0);
            chk("done_nostart", 32'(bus.render_start), 32'd0);
            step(1);
            pulse(0, 0, 1, 0, 0);
            if (r < c_ROWS - 1) begin
                chk("swap_start", 32'(bus.render_start), 32'd1);
                chk("swap_row",   32'(bus.render_row),   32'(r + 1));
            end else begin
                chk("last_nostart", 32'(bus.render_start), 32'd0);
                chk("last_row",     32'(bus.render_row),   32'd3);
            end
        end
        step(2);
        pulse(1, 0, 0, 0, 0);
        chk("f2_req",    32'(bus.vram_sync_req), 32'd1);
        chk("f2_desync", 32'(bus.desync),        32'd0);
        step(2);
        pulse(0, 0, 0, 0, 1);
        chk("f2_frame", 32'(bus.frame_count), 32'd2);

        // Underrun on row 1
        pulse(0, 1, 0, 0, 0);
        pulse(0, 0, 0, 1, 0);
        step(1);
        pulse(0, 0, 1, 0, 0);
        chk("u_row1", 32'(bus.render_row), 32'd1);
        pulse(0, 0, 1, 0, 0);
        chk("u_pulse", 32'(bus.underrun),       32'd1);
        chk("u_count", 32'(bus.underrun_count), 32'd1);
        step(1);
        pulse(0, 0, 0, 1, 0);
        chk("u_start", 32'(bus.render_start), 32'd1);
        chk("u_row2",  32'(bus.render_row),   32'd2);

        // Early vblank while rendering row 2
        step(2);
        pulse(1, 0, 0, 0, 0);
        chk("e_abort",  32'(bus.render_abort),  32'd1);
        chk("e_desync", 32'(bus.desync),        32'd1);
        chk("e_inv",    32'(bus.in_vblank),     32'd1);
        chk("e_start",  32'(bus.render_start),  32'd0);
        step(4);
        chk("e_hold", 32'(bus.vram_sync_req), 32'd1);
        pulse(0, 0, 0, 0, 1);
        chk("e_req0",  32'(bus.vram_sync_req), 32'd0);
        chk("e_frame", 32'(bus.frame_count),   32'd3);

        // Simultaneous done + swap on row 0
        pulse(0, 1, 0, 0, 0);
        step(2);
        pulse(0, 0, 1, 1, 0);
        chk("s_under", 32'(bus.underrun),       32'd0);
        chk("s_start", 32'(bus.render_start),   32'd1);
        chk("s_row",   32'(bus.render_row),     32'd1);
        chk("s_uc",    32'(bus.underrun_count), 32'd1);

        // Saturate the underrun counter
        for (int i = 0; i < 300; i++) begin
            pulse(0, 0, 1, 0, 0);
            step(1);
        end
        chk("sat_uc", 32'(bus.underrun_count), 32'd255);
        pulse(0, 0, 0, 1, 0);
        chk("sat_row2", 32'(bus.render_row), 32'd2);

        // Reset mid-SYNC
        pulse(1, 0, 0, 0, 0);
        chk("r_req1", 32'(bus.vram_sync_req), 32'd1);
        step(1);
        rst = 1'b1;
        step(1);
        chk("r_req0",  32'(bus.vram_sync_req), 32'd0);
        chk("r_frame", 32'(bus.frame_count),   32'd0);
        chk("r_inv",   32'(bus.in_vblank),     32'd0);
        chk("r_abort", 32'(bus.render_abort),  32'd0);
        rst = 1'b0;
        pulse(0, 0, 0, 0, 1);
        pulse(0, 1, 0, 0, 0);
        pulse(0, 0, 0, 1, 0);
        pulse(0, 0, 1, 0, 0);
        step(2);
        chk("st_req",   32'(bus.vram_sync_req), 32'd0);
        chk("st_start", 32'(bus.render_start),  32'd0);
        chk("st_frame", 32'(bus.frame_count),   32'd0);
        chk("st_uc",    32'(bus.underrun_count), 32'd0);
        pulse(1, 0, 0, 0, 0);
        chk("st_sync",   32'(bus.vram_sync_req), 32'd1);
        chk("st_desync", 32'(bus.desync),        32'd0);
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
